smc_arb_lite19: RTL and testbench

SMC_ARB_LITE19 -- requirements
Module: smc_arb_lite19

---
 rtl/smc_arb_lite19_pkg.sv | 25 ++
 rtl/smc_rr_pick19.sv | 29 ++
 rtl/smc_arb_lite19.sv | 149 ++++++++++++++
 tb/tb_smc_arb_lite19.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smc_arb_lite19_pkg.sv
// Shared definitions for the lite19 memory-controller arbiter: FSM encodings,
// default burst/timeout limits and small index helpers.
package smc_defs_lite19;

  typedef logic [1:0] idx_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GRANT   = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam int         MAX_BURST_DEF = 4;
  localparam logic [7:0] TIMEOUT_DEF   = 8'd255;

  function automatic logic [2:0] onehot3(input idx_t idx);
    return 3'b001 << idx;
  endfunction

  // Requester index that follows idx in round-robin order (modulo 3).
  function automatic idx_t next_idx(input idx_t idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/smc_rr_pick19.sv
// Combinational round-robin winner selection over three requesters; the search
// starts at the requester after last_owner.
module smc_rr_pick19
  import smc_defs_lite19::*;
(
  input  logic [2:0] req,
  input  idx_t       last_owner,
  output idx_t       winner,
  output logic       valid
);

  idx_t w_cand;
  logic w_found;

  always_comb begin
    winner  = 2'd0;
    valid   = |req;
    w_found = 1'b0;
    w_cand  = next_idx(last_owner);
    for (int i = 0; i < 3; i++) begin
      if (!w_found && req[w_cand]) begin
        winner  = w_cand;
        w_found = 1'b1;
      end
      w_cand = next_idx(w_cand);
    end
  end

endmodule

// File: rtl/smc_arb_lite19.sv
// Three-requester arbiter in front of the static memory controller: round-robin
// grant, bursts of up to MAX_BURST accesses, WAIT timeout abort.
//
// state   | meaning
// IDLE    | no owner, sampling requests
// GRANT   | owner registered, grant asserted
// START   | one-cycle new_access19 to the controller
// WAIT    | access in flight, timeout counter running
// RELEASE | grant dropped, last_owner updated
module smc_arb_lite19
  import smc_defs_lite19::*;
#(
  parameter int         NUM_REQ   = 3,
  parameter int         MAX_BURST = MAX_BURST_DEF,
  parameter logic [7:0] TIMEOUT   = TIMEOUT_DEF
) (
  input  logic               sys_clk19,
  input  logic               sys_reset19,
  input  logic [NUM_REQ-1:0] req19,
  input  logic [NUM_REQ-1:0] req_last19,
  input  logic [NUM_REQ-1:0] req_n_read19,
  input  logic [NUM_REQ-1:0] req_cs19,
  input  logic               smc_done19,
  input  logic               mac_done19,
  output logic [NUM_REQ-1:0] gnt19,
  output logic [NUM_REQ-1:0] ack19,
  output logic [NUM_REQ-1:0] err19,
  output logic               new_access19,
  output logic               cs19,
  output logic               n_read19,
  output logic [1:0]         owner19,
  output logic               arb_busy19
);

  localparam logic [2:0] LP_MAX_BURST = 3'(MAX_BURST);
  localparam logic [7:0] LP_TMO_LAST  = TIMEOUT - 8'd1;

  logic [2:0]         r_state;
  idx_t               r_last_owner;
  idx_t               r_owner;
  logic [2:0]         r_burst;
  logic [7:0]         r_tmo;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_ack;
  logic [NUM_REQ-1:0] r_err;
  logic               r_new_access;
  logic               r_cs;
  logic               r_n_read;

  idx_t w_winner;
  logic w_valid;
  logic w_done;
  logic w_tmo_hit;
  logic w_release;

  smc_rr_pick19 u_pick (
    .req        (req19),
    .last_owner (r_last_owner),
    .winner     (w_winner),
    .valid      (w_valid)
  );

  assign w_done    = smc_done19 & mac_done19;
  assign w_tmo_hit = (r_tmo == LP_TMO_LAST);
  assign w_release = req_last19[r_owner] | ~req19[r_owner] |
                     (r_burst + 3'd1 == LP_MAX_BURST);

  always_ff @(posedge sys_clk19 or posedge sys_reset19) begin
    if (sys_reset19) begin
      r_state      <= ST_IDLE;
      r_last_owner <= 2'd2;
      r_owner      <= 2'd0;
      r_burst      <= 3'd0;
      r_tmo        <= 8'd0;
      r_gnt        <= '0;
      r_ack        <= '0;
      r_err        <= '0;
      r_new_access <= 1'b0;
      r_cs         <= 1'b0;
      r_n_read     <= 1'b0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_owner <= w_winner;
            r_gnt   <= onehot3(w_winner);
            r_burst <= 3'd0;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          r_new_access <= 1'b1;
          r_cs         <= req_cs19[r_owner];
          r_n_read     <= req_n_read19[r_owner];
          r_tmo        <= 8'd0;
          r_state      <= ST_START;
        end
        ST_START: begin
          r_new_access <= 1'b0;
          r_state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion wins over a timeout landing in the same cycle.
          if (w_done) begin
            r_ack   <= onehot3(r_owner);
            r_burst <= (r_burst == LP_MAX_BURST) ? r_burst : r_burst + 3'd1;
            if (w_release) begin
              r_gnt    <= '0;
              r_cs     <= 1'b0;
              r_n_read <= 1'b0;
              r_state  <= ST_RELEASE;
            end else begin
              r_new_access <= 1'b1;
              r_cs         <= req_cs19[r_owner];
              r_n_read     <= req_n_read19[r_owner];
              r_tmo        <= 8'd0;
              r_state      <= ST_START;
            end
          end else if (w_tmo_hit) begin
            r_err    <= onehot3(r_owner);
            r_gnt    <= '0;
            r_cs     <= 1'b0;
            r_n_read <= 1'b0;
            r_state  <= ST_RELEASE;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        ST_RELEASE: begin
          r_last_owner <= r_owner;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt19        = r_gnt;
  assign ack19        = r_ack;
  assign err19        = r_err;
  assign new_access19 = r_new_access;
  assign cs19         = r_cs;
  assign n_read19     = r_n_read;
  assign owner19      = r_owner;
  assign arb_busy19   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_smc_arb_lite19.sv
// Self-checking bench for smc_arb_lite19: table of round-robin grants, random
// transactions against a transaction-level model, plus timeout/reset corners.
module tb_smc_arb_lite19;

  logic       sys_clk19 = 1'b0;
  logic       sys_reset19;
  logic [2:0] req19, req_last19, req_n_read19, req_cs19;
  logic       smc_done19, mac_done19;
  logic [2:0] gnt19, ack19, err19;
  logic       new_access19, cs19, n_read19, arb_busy19;
  logic [1:0] owner19;

  int n_chk  = 0;
  int n_fail = 0;
  logic [1:0] m_last;

  typedef struct {
    logic [2:0] req;
    logic [2:0] cs;
    logic [2:0] nrd;
    logic [1:0] exp_w;
  } vec_t;

  vec_t vecs [10];

  smc_arb_lite19 dut (
    .sys_clk19    (sys_clk19),
    .sys_reset19  (sys_reset19),
    .req19        (req19),
    .req_last19   (req_last19),
    .req_n_read19 (req_n_read19),
    .req_cs19     (req_cs19),
    .smc_done19   (smc_done19),
    .mac_done19   (mac_done19),
    .gnt19        (gnt19),
    .ack19        (ack19),
    .err19        (err19),
    .new_access19 (new_access19),
    .cs19         (cs19),
    .n_read19     (n_read19),
    .owner19      (owner19),
    .arb_busy19   (arb_busy19)
  );

  always #5 sys_clk19 = ~sys_clk19;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requesting index after the previous owner, mod 3.
  function automatic logic [1:0] rr_model(input logic [2:0] req, input logic [1:0] last);
    for (int i = 1; i <= 3; i++) begin
      int idx;
      idx = (int'(last) + i) % 3;
      if (req[idx]) return 2'(idx);
    end
    return 2'd0;
  endfunction

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  task automatic wait_grant(input logic [1:0] exp_w, input bit chk_gap, input string name);
    int waited;
    waited = 0;
    do begin
      @(negedge sys_clk19);
      waited++;
    end while (gnt19 == 3'b000 && waited < 20);
    chk({name, "_gnt"}, gnt19, 3'b001 << exp_w);
    chk({name, "_owner"}, owner19, exp_w);
    if (chk_gap) chk({name, "_regrant_gap"}, waited, 2);
  endtask

  // One grant: accesses served with a done pulse 'delay' WAIT cycles after each
  // new_access19 (0 = random 1..4); owner raises req_last at access last_after
  // and drops its request at access drop_at. Owner's cs/n_read inputs are
  // inverted during WAIT to prove the outputs are held.
  task automatic run_txn(input logic [2:0] req, input logic [2:0] cs, input logic [2:0] nrd,
                         input int last_after, input int drop_at, input int delay,
                         input logic [1:0] exp_w, input int exp_acc, input bit chk_gap,
                         input string name);
    int  k, acks, cd;
    bit  drove, done_ok;
    logic [2:0] oh;
    logic exp_cs, exp_nrd;
    req19 = req; req_cs19 = cs; req_n_read19 = nrd;
    req_last19 = 3'b000; smc_done19 = 1'b0; mac_done19 = 1'b0;
    wait_grant(exp_w, chk_gap, name);
    oh = 3'b001 << exp_w;
    exp_cs = cs[exp_w]; exp_nrd = nrd[exp_w];
    k = 0; acks = 0; cd = 0; drove = 0; done_ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge sys_clk19);
      smc_done19 = 1'b0; mac_done19 = 1'b0; req_last19 = 3'b000;
      chk({name, "_gnt_onehot0"}, $onehot0(gnt19), 1);
      chk({name, "_ackerr_onehot0"}, $onehot0(ack19 | err19), 1);
      chk({name, "_no_err"}, err19, 3'b000);
      if (drove) begin
        chk({name, "_ack"}, ack19, oh);
        if (ack19 == oh) acks++;
        drove = 0;
        if (gnt19 != 3'b000) chk({name, "_b2b_start"}, new_access19, 1);
      end else begin
        chk({name, "_no_ack"}, ack19, 3'b000);
      end
      if (gnt19 == 3'b000) begin
        done_ok = 1;
        break;
      end
      chk({name, "_owner_hold"}, owner19, exp_w);
      if (new_access19) begin
        k++;
        chk({name, "_cs_start"}, cs19, exp_cs);
        chk({name, "_nrd_start"}, n_read19, exp_nrd);
        req_cs19[exp_w] = ~exp_cs;
        req_n_read19[exp_w] = ~exp_nrd;
        cd = (delay > 0) ? delay : int'($urandom_range(1, 4));
      end else begin
        chk({name, "_cs_hold"}, cs19, exp_cs);
        chk({name, "_nrd_hold"}, n_read19, exp_nrd);
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            smc_done19 = 1'b1; mac_done19 = 1'b1;
            req_last19[exp_w] = (k == last_after);
            if (k == drop_at) req19[exp_w] = 1'b0;
            req_cs19[exp_w] = exp_cs;
            req_n_read19[exp_w] = exp_nrd;
            drove = 1;
          end
        end
      end
    end
    chk({name, "_release_seen"}, done_ok, 1);
    chk({name, "_accesses"}, k, exp_acc);
    chk({name, "_acks"}, acks, exp_acc);
  endtask

  // Done withheld: abort after 255 WAIT cycles. With done_at_last the
  // completion lands on the terminal WAIT cycle and must win.
  task automatic run_timeout(input logic [1:0] w, input bit done_at_last, input string name);
    logic [2:0] oh;
    oh = 3'b001 << w;
    req19 = oh; req_last19 = 3'b111; req_cs19 = 3'b000; req_n_read19 = 3'b000;
    smc_done19 = 1'b0; mac_done19 = 1'b0;
    wait_grant(w, 1'b0, name);
    @(negedge sys_clk19);
    chk({name, "_start"}, new_access19, 1);
    for (int n = 1; n <= 256; n++) begin
      @(negedge sys_clk19);
      smc_done19 = 1'b0; mac_done19 = 1'b0;
      if (n < 256) begin
        if (ack19 != 3'b000 || err19 != 3'b000 || gnt19 != oh)
          chk({name, "_early_end"}, n, 256);
        if (done_at_last && n == 255) begin
          smc_done19 = 1'b1; mac_done19 = 1'b1;
        end
      end else begin
        chk({name, "_ack"}, ack19, done_at_last ? oh : 3'b000);
        chk({name, "_err"}, err19, done_at_last ? 3'b000 : oh);
        chk({name, "_gnt_off"}, gnt19, 3'b000);
      end
    end
    @(negedge sys_clk19);
    req19 = 3'b000; req_last19 = 3'b000;
    chk({name, "_idle"}, arb_busy19, 0);
    chk({name, "_pulse_over"}, ack19 | err19, 3'b000);
    m_last = w;
  endtask

  initial begin
    logic [2:0] rq;
    logic [1:0] w;
    int la, da;

    vecs[0] = '{3'b111, 3'b001, 3'b000, 2'd0};
    vecs[1] = '{3'b111, 3'b010, 3'b010, 2'd1};
    vecs[2] = '{3'b111, 3'b100, 3'b000, 2'd2};
    vecs[3] = '{3'b011, 3'b000, 3'b001, 2'd0};
    vecs[4] = '{3'b101, 3'b100, 3'b100, 2'd2};
    vecs[5] = '{3'b110, 3'b010, 3'b000, 2'd1};
    vecs[6] = '{3'b001, 3'b001, 3'b001, 2'd0};
    vecs[7] = '{3'b001, 3'b000, 3'b000, 2'd0};
    vecs[8] = '{3'b100, 3'b100, 3'b000, 2'd2};
    vecs[9] = '{3'b010, 3'b000, 3'b010, 2'd1};

    sys_reset19 = 1'b1;
    req19 = 3'b000; req_last19 = 3'b000; req_n_read19 = 3'b000; req_cs19 = 3'b000;
    smc_done19 = 1'b0; mac_done19 = 1'b0;
    @(negedge sys_clk19);
    chk("rst_gnt", gnt19, 0);
    chk("rst_ackerr", {ack19, err19}, 0);
    chk("rst_misc", {new_access19, cs19, n_read19, owner19, arb_busy19}, 0);
    @(negedge sys_clk19);
    sys_reset19 = 1'b0;
    repeat (3) begin
      @(negedge sys_clk19);
      chk("idle_no_grant", gnt19, 0);
      chk("idle_not_busy", arb_busy19, 0);
    end

    m_last = 2'd2;
    foreach (vecs[i]) begin
      run_txn(vecs[i].req, vecs[i].cs, vecs[i].nrd, 1, 9, 0, vecs[i].exp_w, 1,
              (i > 0), $sformatf("vec%0d", i));
      m_last = vecs[i].exp_w;
    end

    w = rr_model(3'b010, m_last);
    run_txn(3'b010, 3'b010, 3'b000, 9, 9, 2, w, 4, 1'b1, "burst4");
    m_last = w;

    for (int t = 0; t < 40; t++) begin
      rq = 3'($urandom_range(1, 7));
      w  = rr_model(rq, m_last);
      la = $urandom_range(1, 6);
      da = $urandom_range(1, 8);
      run_txn(rq, 3'($urandom), 3'($urandom), la, da, 0, w, min3(la, da, 4), 1'b1,
              $sformatf("rnd%0d", t));
      m_last = w;
    end

    run_timeout(2'd1, 1'b0, "timeout");
    run_timeout(2'd0, 1'b1, "done_vs_tmo");

    req19 = 3'b001; req_cs19 = 3'b001; req_n_read19 = 3'b001; req_last19 = 3'b000;
    wait_grant(rr_model(3'b001, m_last), 1'b0, "rstmid");
    @(negedge sys_clk19);
    @(negedge sys_clk19);
    chk("rstmid_in_wait", {cs19, n_read19, arb_busy19}, 3'b111);
    sys_reset19 = 1'b1;
    #1;
    chk("rstmid_gnt", gnt19, 0);
    chk("rstmid_ackerr", {ack19, err19}, 0);
    chk("rstmid_misc", {new_access19, cs19, n_read19, owner19, arb_busy19}, 0);
    @(negedge sys_clk19);
    sys_reset19 = 1'b0;
    req19 = 3'b000;
    run_txn(3'b100, 3'b100, 3'b100, 1, 9, 0, 2'd2, 1, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
